// File: rtl/flash_prog_pkg.sv
// Shared constants and state encoding for the flash command parser.
package flash_prog_pkg;

  localparam logic [7:0] HDR_B0      = 8'hEF;
  localparam logic [7:0] HDR_B1      = 8'hFE;
  localparam logic [7:0] HDR_B2      = 8'h03;
  localparam logic [7:0] CMD_PROGRAM = 8'h01;
  localparam logic [7:0] CMD_ERASE   = 8'h02;

  localparam int unsigned PAGE_BYTES = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_COUNT,
    ST_DATA,
    ST_DROP,
    ST_ERASE_SEQ
  } state_t;

endpackage

// File: rtl/be_shift32.sv
// Four-byte big-endian field collector; done flags the shift that completes the word.
module be_shift32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] value,
  output logic [31:0] assembled,
  output logic        done
);

  logic [1:0] byte_cnt;

  // assembled is the word as it will read once din has been shifted in
  assign assembled = {value[23:0], din};
  assign done      = shift_en && (byte_cnt == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      value    <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      value    <= assembled;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/flash_prog_rx.sv
// Parses erase / program-block commands from the UDP payload stream and
// admits whole 256-byte pages into the flash writer's Rx FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for a start-of-frame byte EF
// HDR        | matching FE, 03 and the command code
// SEQ        | collecting 4-byte sequence number (program)
// COUNT      | collecting 4-byte block count, admission decision
// DATA       | forwarding page bytes to the FIFO
// DROP       | discarding the rest of a rejected frame
// ERASE_SEQ  | collecting sequence number, then raising erase
module flash_prog_rx #(
  parameter int unsigned PAGE_BYTES = flash_prog_pkg::PAGE_BYTES,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic [9:0]  fifo_used,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        erase,
  input  logic        erase_ACK,
  output logic [13:0] num_blocks,
  output logic [31:0] seq_num,
  output logic [7:0]  dropped
);

  import flash_prog_pkg::*;

  localparam logic [9:0] ADMIT_LIMIT = 10'(FIFO_DEPTH - PAGE_BYTES);
  localparam logic [8:0] LAST_BYTE   = 9'(PAGE_BYTES - 1);

  state_t      state, state_nxt;
  logic [1:0]  hdr_idx;
  logic [8:0]  data_cnt;

  logic        byte_in, sop_in;
  logic        sr_clr, seq_shift, cnt_shift;
  logic        seq_done, cnt_done;
  logic        fits;
  logic        wr_en, admit, reject, erase_done, abort_data;
  logic [31:0] seq_value, seq_assembled;
  logic [31:0] unused_cnt_value, cnt_assembled;
  logic        unused_cnt_hi;

  assign byte_in = rx_valid && !rx_sop;
  assign sop_in  = rx_valid && rx_sop;
  assign fits    = (fifo_used <= ADMIT_LIMIT);
  assign unused_cnt_hi = ^cnt_assembled[31:14];

  be_shift32 u_seq_sr (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (sr_clr),
    .shift_en  (seq_shift),
    .din       (rx_data),
    .value     (seq_value),
    .assembled (seq_assembled),
    .done      (seq_done)
  );

  be_shift32 u_cnt_sr (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (sr_clr),
    .shift_en  (cnt_shift),
    .din       (rx_data),
    .value     (unused_cnt_value),
    .assembled (cnt_assembled),
    .done      (cnt_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A start-of-frame byte restarts parsing from any state
  always_comb begin
    state_nxt = state;
    if (sop_in) begin
      state_nxt = (rx_data == HDR_B0) ? ST_HDR : ST_IDLE;
    end else if (byte_in) begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_HDR: begin
          case (hdr_idx)
            2'd0:    if (rx_data != HDR_B1) state_nxt = ST_IDLE;
            2'd1:    if (rx_data != HDR_B2) state_nxt = ST_IDLE;
            default: begin
              if (rx_data == CMD_ERASE)        state_nxt = ST_ERASE_SEQ;
              else if (rx_data == CMD_PROGRAM) state_nxt = ST_SEQ;
              else                             state_nxt = ST_IDLE;
            end
          endcase
        end
        ST_SEQ:       if (seq_done) state_nxt = ST_COUNT;
        ST_COUNT:     if (cnt_done) state_nxt = fits ? ST_DATA : ST_DROP;
        ST_DATA:      if (data_cnt == LAST_BYTE) state_nxt = ST_IDLE;
        ST_DROP:      state_nxt = ST_DROP;
        ST_ERASE_SEQ: if (seq_done) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sr_clr     = (state == ST_HDR) || sop_in;
    seq_shift  = byte_in && ((state == ST_SEQ) || (state == ST_ERASE_SEQ));
    cnt_shift  = byte_in && (state == ST_COUNT);
    wr_en      = byte_in && (state == ST_DATA);
    admit      = (state == ST_COUNT) && cnt_done && fits;
    reject     = (state == ST_COUNT) && cnt_done && !fits;
    erase_done = (state == ST_ERASE_SEQ) && seq_done;
    abort_data = sop_in && (state == ST_DATA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_idx  <= '0;
      data_cnt <= '0;
    end else begin
      if (sop_in || (state != ST_HDR)) hdr_idx <= '0;
      else if (byte_in)                hdr_idx <= hdr_idx + 2'd1;

      if (sop_in || (state != ST_DATA)) data_cnt <= '0;
      else if (wr_en)                   data_cnt <= data_cnt + 9'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      erase      <= 1'b0;
      num_blocks <= '0;
      seq_num    <= '0;
      dropped    <= '0;
    end else begin
      fifo_wrreq <= wr_en;
      if (wr_en) fifo_data <= rx_data;

      if (admit) begin
        num_blocks <= cnt_assembled[13:0];
        seq_num    <= seq_value;
      end
      if (erase_done) seq_num <= seq_assembled;

      // An ack in the same cycle as a new erase frame wins: the frame is absorbed
      if (erase && erase_ACK) erase <= 1'b0;
      else if (erase_done)    erase <= 1'b1;

      if ((reject || abort_data) && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_flash_prog_rx.sv
// Directed bench for flash_prog_rx: erase handshake, page admission, aborts, reset.
module tb_flash_prog_rx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic [9:0]  fifo_used = '0;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic        erase;
  logic        erase_ACK = 1'b0;
  logic [13:0] num_blocks;
  logic [31:0] seq_num;
  logic [7:0]  dropped;

  int errors = 0;
  int checks = 0;
  logic [7:0] wr_log[$];

  always #5 clock = ~clock;

  flash_prog_rx #(.PAGE_BYTES(256), .FIFO_DEPTH(1024)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .fifo_used  (fifo_used),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .erase      (erase),
    .erase_ACK  (erase_ACK),
    .num_blocks (num_blocks),
    .seq_num    (seq_num),
    .dropped    (dropped)
  );

  always @(negedge clock) begin
    if (fifo_wrreq === 1'b1) wr_log.push_back(fifo_data);
  end

  task automatic send_byte(input logic [7:0] b, input logic sop);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_sop   = sop;
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 1'b0);
  endtask

  task automatic send_program(input logic [31:0] seq, input logic [31:0] cnt,
                              input int ndata, input logic [7:0] base);
    logic [7:0] b;
    send_byte(8'hEF, 1'b1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(seq);
    send_word(cnt);
    for (int i = 0; i < ndata; i++) begin
      b = base + 8'(i);
      send_byte(b, 1'b0);
    end
  endtask

  task automatic send_erase(input logic [31:0] seq);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(seq);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq got=%b exp=0", fifo_wrreq); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", fifo_data); end
    checks++; if (erase !== 1'b0) begin errors++; $display("FAIL reset_erase got=%b exp=0", erase); end
    checks++; if (num_blocks !== 14'd0) begin errors++; $display("FAIL reset_num_blocks got=%0d exp=0", num_blocks); end
    checks++; if (seq_num !== 32'd0) begin errors++; $display("FAIL reset_seq_num got=%h exp=0", seq_num); end
    checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_erase;
    int bad;
    wr_log.delete();
    send_erase(32'h0000_0007);
    idle(0);
    checks++; if (erase !== 1'b1) begin errors++; $display("FAIL erase_rise got=%b exp=1", erase); end
    checks++; if (seq_num !== 32'd7) begin errors++; $display("FAIL erase_seq got=%h exp=7", seq_num); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (erase !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL erase_hold low_cycles=%0d exp=0", bad); end
    send_erase(32'h0000_0008);
    idle(2);
    checks++; if (erase !== 1'b1) begin errors++; $display("FAIL erase_absorb got=%b exp=1", erase); end
    erase_ACK = 1'b1;
    @(negedge clock);
    checks++; if (erase !== 1'b0) begin errors++; $display("FAIL erase_ack_clear got=%b exp=0", erase); end
    erase_ACK = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (erase !== 1'b0) begin errors++; $display("FAIL erase_no_second got=%b exp=0", erase); end
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL erase_no_writes got=%0d exp=0", wr_log.size()); end
  endtask

  task automatic test_program;
    int bad;
    wr_log.delete();
    fifo_used = 10'd0;
    send_program(32'h1122_3344, 32'h0000_0005, 256, 8'h00);
    idle(3);
    checks++; if (wr_log.size() != 256) begin errors++; $display("FAIL prog_count got=%0d exp=256", wr_log.size()); end
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL prog_data bad_bytes=%0d exp=0", bad); end
    checks++; if (num_blocks !== 14'd5) begin errors++; $display("FAIL prog_num_blocks got=%0d exp=5", num_blocks); end
    checks++; if (seq_num !== 32'h1122_3344) begin errors++; $display("FAIL prog_seq got=%h exp=11223344", seq_num); end
    checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL prog_dropped got=%0d exp=0", dropped); end
  endtask

  task automatic test_admission;
    int bad;
    wr_log.delete();
    fifo_used = 10'd769;
    send_program(32'h0000_0020, 32'h0000_0009, 256, 8'h00);
    idle(3);
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL reject_writes got=%0d exp=0", wr_log.size()); end
    checks++; if (dropped !== 8'd1) begin errors++; $display("FAIL reject_dropped got=%0d exp=1", dropped); end
    checks++; if (num_blocks !== 14'd5) begin errors++; $display("FAIL reject_num_blocks got=%0d exp=5", num_blocks); end
    checks++; if (seq_num !== 32'h1122_3344) begin errors++; $display("FAIL reject_seq got=%h exp=11223344", seq_num); end
    wr_log.delete();
    fifo_used = 10'd768;
    send_program(32'h0000_0021, 32'h1234_5678, 256, 8'h40);
    idle(3);
    checks++; if (wr_log.size() != 256) begin errors++; $display("FAIL admit768_count got=%0d exp=256", wr_log.size()); end
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 8'(8'h40 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL admit768_data bad_bytes=%0d exp=0", bad); end
    checks++; if (num_blocks !== 14'h1678) begin errors++; $display("FAIL admit768_num_blocks got=%h exp=1678", num_blocks); end
    checks++; if (dropped !== 8'd1) begin errors++; $display("FAIL admit768_dropped got=%0d exp=1", dropped); end
    fifo_used = 10'd0;
  endtask

  task automatic test_bad_cmd;
    wr_log.delete();
    send_byte(8'hEF, 1'b1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(8'h5A, 1'b0);
    idle(3);
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL badcmd_writes got=%0d exp=0", wr_log.size()); end
    checks++; if (erase !== 1'b0) begin errors++; $display("FAIL badcmd_erase got=%b exp=0", erase); end
    send_program(32'h0000_0030, 32'h0000_0002, 256, 8'h80);
    idle(3);
    checks++; if (wr_log.size() != 256) begin errors++; $display("FAIL badcmd_next_count got=%0d exp=256", wr_log.size()); end
    checks++; if (num_blocks !== 14'd2) begin errors++; $display("FAIL badcmd_num_blocks got=%0d exp=2", num_blocks); end
  endtask

  task automatic test_back_to_back_abort;
    int bad;
    wr_log.delete();
    send_program(32'h0000_0040, 32'h0000_0003, 100, 8'h00);
    send_program(32'h0000_0041, 32'h0000_0004, 256, 8'h00);
    idle(3);
    checks++; if (wr_log.size() != 356) begin errors++; $display("FAIL abort_count got=%0d exp=356", wr_log.size()); end
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (i < 100) begin
        if (wr_log[i] !== 8'(i)) bad++;
      end else begin
        if (wr_log[i] !== 8'(i - 100)) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_data bad_bytes=%0d exp=0", bad); end
    checks++; if (dropped !== 8'd2) begin errors++; $display("FAIL abort_dropped got=%0d exp=2", dropped); end
    checks++; if (seq_num !== 32'h0000_0041) begin errors++; $display("FAIL abort_seq got=%h exp=41", seq_num); end
    checks++; if (num_blocks !== 14'd4) begin errors++; $display("FAIL abort_num_blocks got=%0d exp=4", num_blocks); end
  endtask

  task automatic test_reset_mid;
    int bad;
    send_program(32'h0000_0050, 32'h0000_0006, 50, 8'h00);
    @(negedge clock);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    reset_n  = 1'b0;
    #1;
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL rstmid_wrreq got=%b exp=0", fifo_wrreq); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", fifo_data); end
    checks++; if (num_blocks !== 14'd0) begin errors++; $display("FAIL rstmid_num_blocks got=%0d exp=0", num_blocks); end
    checks++; if (seq_num !== 32'd0) begin errors++; $display("FAIL rstmid_seq got=%h exp=0", seq_num); end
    checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL rstmid_dropped got=%0d exp=0", dropped); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wr_log.delete();
    send_byte(8'h33, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    idle(3);
    checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL rstmid_discard got=%0d exp=0", wr_log.size()); end
    send_program(32'h0000_0051, 32'h0000_0007, 256, 8'h10);
    idle(3);
    checks++; if (wr_log.size() != 256) begin errors++; $display("FAIL rstmid_new_count got=%0d exp=256", wr_log.size()); end
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 8'(8'h10 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_new_data bad_bytes=%0d exp=0", bad); end
    checks++; if (seq_num !== 32'h0000_0051) begin errors++; $display("FAIL rstmid_new_seq got=%h exp=51", seq_num); end
  endtask

  task automatic test_saturate;
    fifo_used = 10'd1000;
    for (int i = 0; i < 254; i++) send_program(32'(i), 32'h1, 0, 8'h00);
    idle(2);
    checks++; if (dropped !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", dropped); end
    for (int i = 0; i < 6; i++) send_program(32'(i), 32'h1, 0, 8'h00);
    idle(2);
    checks++; if (dropped !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", dropped); end
    fifo_used = 10'd0;
  endtask

  initial begin
    test_reset();
    test_erase();
    test_program();
    test_admission();
    test_bad_cmd();
    test_back_to_back_abort();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_prog_rx.md
# flash_prog_rx

Upstream parser for the remote-reprogramming path. It takes the byte stream of received UDP payloads and recognises the two flash commands: erase and program block. For erase it raises the erase request. For program it captures the block count and writes the 256-byte page payload into the 1024-deep Rx FIFO that feeds the ASMI flash writer. Frames are checked and admitted whole, so the writer only ever sees complete 256-byte pages.

## Interface
Parameters:
- PAGE_BYTES, 256, payload bytes per program frame
- FIFO_DEPTH, 1024, depth of downstream Rx FIFO (words of 8 bits)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  UDP payload byte
- rx_valid  in  1  rx_data valid this cycle
- rx_sop  in  1  first payload byte of a frame (qualified by rx_valid)
- fifo_used  in  10  Rx FIFO fill level (words)
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  8  FIFO write data (bit order unchanged; the writer reverses)
- erase  out  1  erase request, level
- erase_ACK  in  1  writer has accepted erase
- num_blocks  out  14  total page count of current programming session
- seq_num  out  32  sequence number of last admitted frame
- dropped  out  8  saturating count of discarded program frames

## Operation
- Frame format: bytes 0-3 header EF FE 03 cc.
  - cc=01: program. cc=02: erase.
  - Bytes 4-7: sequence number, MSB first.
  - Program frames only:
    - Bytes 8-11: block count, MSB first; the low 14 bits go to num_blocks.
    - Bytes 12-267: page data.
- States:
  - IDLE: wait for rx_valid&rx_sop with byte EF, then go to HDR.
  - HDR: match FE, 03, then cc. On cc=02 go to ERASE_SEQ; on cc=01 go to SEQ. Any mismatch goes to IDLE.
  - SEQ: shift in 4 bytes, then go to COUNT.
  - COUNT: shift in 4 bytes.
    - On the 4th byte, admit the frame iff fifo_used <= FIFO_DEPTH-PAGE_BYTES (768).
    - Admit: latch num_blocks and seq_num, go to DATA.
    - Reject: dropped++ (saturate at 255), go to DROP.
  - DATA: each valid byte gives fifo_wrreq=1 with fifo_data=rx_data. After the 256th byte go to IDLE.
  - DROP: consume bytes until the next rx_sop.
  - ERASE_SEQ: shift in 4 bytes, latch seq_num, set erase=1, go to IDLE.
- Erase handshake:
  - erase stays high until erase_ACK is sampled high, then clears the next cycle.
  - A new erase frame while erase=1 is absorbed (no second pulse).
- rx_sop with rx_valid in any state other than IDLE aborts the current frame and reparses the byte as a new header.
  - If this happens in DATA, the partially written page remains in the FIFO and dropped increments.
  - The page-size rule is therefore violated. Upstream must never truncate frames.
- Bytes with rx_valid=0 are ignored in every state.
- rx_sop at IDLE with a byte other than EF: stay in IDLE.

## Timing
- Reset values: fifo_wrreq=0, fifo_data=0, erase=0, num_blocks=0, seq_num=0, dropped=0, state IDLE.
- Latency: registered, one cycle from an accepted rx_data byte to fifo_wrreq/fifo_data.
- Back-to-back valid bytes are supported at full rate; 256 consecutive writes are possible.
- num_blocks and seq_num update on the cycle after the 4th count byte. They are stable for the whole DATA phase.
- erase rises one cycle after the last erase sequence byte. It clears one cycle after erase_ACK is first seen high.
- Admission check uses fifo_used sampled on the 4th count byte. fifo_used == 768 admits; 769 rejects.
- Asserting reset mid-frame clears everything immediately. Bytes after reset release are discarded until the next rx_sop.

## Structure
- Shared package flash_prog_pkg:
  - header constants (8'hEF, 8'hFE, 8'h03)
  - command codes (CMD_PROGRAM=8'h01, CMD_ERASE=8'h02)
  - state enum
  - PAGE_BYTES
- One sub-module, be_shift32: a 4-byte big-endian shift register with byte counter, reused for the sequence and block-count fields.
- Main module: parser FSM, 9-bit data byte counter, admission compare, erase handshake.

## Test plan
- Erase frame EF FE 03 02 00 00 00 07:
  - erase goes high, seq_num=7.
  - Hold erase_ACK low for 10 cycles: erase stays 1. Raise erase_ACK: erase=0 next cycle.
- Program frame, count=00 00 00 05, data 0x00..0xFF, fifo_used=0:
  - exactly 256 fifo_wrreq pulses with data in order, num_blocks=5, dropped=0.
- Same frame with fifo_used=769:
  - zero writes, dropped=1. With fifo_used=768 the frame is written fully.
- Header EF FE 03 05 (bad cc), then a valid program frame:
  - bad frame produces no writes and no erase; the next frame writes 256 bytes.
- Program frame with rx_sop injected after 100 data bytes, followed by a full program frame:
  - 100 + 256 writes, dropped=1.
- Reset_n pulsed low during DATA byte 50, then a fresh frame:
  - outputs at reset values during reset; exactly 256 writes for the new frame.
